// File: rtl/rotate_pkg.sv
// Shared constants and FSM encoding for the sequential right rotator.
package rotate_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_AMT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rotate_right_seq.sv
// Sequential rotate-right, one bit per cycle; inverse of the left rotator.
// Optional ROTR_SHIFT_MODE_EN adds a mode port selecting logical shift right.
module rotate_right_seq
  import rotate_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
`ifdef ROTR_SHIFT_MODE_EN
  input  logic             mode,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [AMT_W-1:0] counter;
  logic             fill_bit;

`ifdef ROTR_SHIFT_MODE_EN
  logic fill_zero;

  always_comb begin
    fill_bit = fill_zero ? 1'b0 : data_out[0];
  end
`else
  always_comb begin
    fill_bit = data_out[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= '0;
      counter  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ROTR_SHIFT_MODE_EN
      fill_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            data_out <= data_in;
            counter  <= amount;
            busy     <= 1'b1;
`ifdef ROTR_SHIFT_MODE_EN
            fill_zero <= mode;
`endif
            // A zero count skips SHIFT entirely so done follows one cycle later.
            if (amount != '0) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          data_out <= {fill_bit, data_out[WIDTH-1:1]};
          counter  <= counter - AMT_W'(1);
          if (counter == AMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_right_seq.sv
// Bench for rotate_right_seq: arithmetic reference model checked every cycle
// plus directed operations with hand-computed results and latencies.
module tb_rotate_right_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [2:0]   amount = '0;
  logic         mode = 1'b0;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;
  int n_done = 0;

  rotate_right_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .amount   (amount),
`ifdef ROTR_SHIFT_MODE_EN
    .mode     (mode),
`endif
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x, input int n, input bit zf);
    logic [W-1:0] r;
    if (zf) r = x >> n;
    else    r = (x >> n) | (x << (W - n));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result after k steps is the operand rotated by k.
  bit           m_ok = 1'b0;
  bit           m_busy, m_done, m_zf;
  logic [W-1:0] m_out, m_x;
  int           m_amt, m_steps;

  always @(posedge clk) begin
    if (reset) begin
      m_ok = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_out = '0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (start) begin
          m_x = data_in; m_amt = int'(amount); m_steps = 0; m_out = data_in;
`ifdef ROTR_SHIFT_MODE_EN
          m_zf = mode;
`else
          m_zf = 1'b0;
`endif
          m_busy = 1'b1; m_done = (amount == 3'd0);
        end
      end else if (m_done) begin
        m_busy = 1'b0; m_done = 1'b0;
      end else begin
        m_steps++;
        m_out = ref_rot(m_x, m_steps, m_zf);
        if (m_steps == m_amt) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_data_out", data_out, m_out);
    end
    if (done === 1'b1) n_done++;
  end

  task automatic run_op(input logic [W-1:0] x, input logic [2:0] a, input bit md,
                        input logic [W-1:0] exp_out, input int exp_lat, input bit inject);
    int lat;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; data_in = x; amount = a; mode = md;
    @(posedge clk); #1;
    start = 1'b0; data_in = '0; amount = '0; mode = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_after_start", busy, 1);
      if (inject && lat == 1) begin start = 1'b1; data_in = 8'hFF; amount = 3'd1; end
      if (inject && lat == 2) begin start = 1'b0; data_in = '0; amount = '0; end
      seen = (done === 1'b1);
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("latency", lat, exp_lat);
      chk("result", data_out, exp_out);
    end
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_data", data_out, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op(8'h7B, 3'd1, 1'b0, 8'hBD, 2, 1'b0);
    run_op(8'h7B, 3'd0, 1'b0, 8'h7B, 1, 1'b0);
    run_op(8'h7B, 3'd7, 1'b0, 8'hF6, 8, 1'b0);
    run_op(8'h7B, 3'd3, 1'b0, 8'h6F, 4, 1'b0);
    run_op(8'h96, 3'd2, 1'b0, 8'hA5, 3, 1'b0);
    run_op(8'h81, 3'd4, 1'b0, 8'h18, 5, 1'b0);
    run_op(8'h01, 3'd1, 1'b0, 8'h80, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_after_done", data_out, 8'h80);

    d0 = n_done;
    run_op(8'h7B, 3'd3, 1'b0, 8'h6F, 4, 1'b1);
    repeat (6) @(negedge clk);
    chk("single_done_on_ignored_start", n_done - d0, 1);

    @(posedge clk); #1;
    start = 1'b1; data_in = 8'h7B; amount = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d0 = n_done;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_data", data_out, 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

    reset = 1'b1; start = 1'b1; data_in = 8'h55; amount = 3'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("reset_over_start_busy", busy, 0);
    chk("reset_over_start_data", data_out, 8'h00);

    run_op(8'h7B, 3'd3, 1'b0, 8'h6F, 4, 1'b0);
    run_op(8'hC3, 3'd6, 1'b0, 8'h0F, 7, 1'b0);
`ifdef ROTR_SHIFT_MODE_EN
    run_op(8'h7B, 3'd3, 1'b1, 8'h0F, 4, 1'b0);
    run_op(8'h80, 3'd7, 1'b1, 8'h01, 8, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
